// File: rtl/seven_seg_scan_ctrl_if.sv
// Bus bundle for the four-digit seven-segment scan controller.
// The slave side is the controller; the master side is whatever feeds it.
interface seven_seg_scan_ctrl_if;
  logic        enable;
  logic [15:0] digit_data;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic [3:0]  brightness;
  logic        upd_req;
  logic        upd_ack;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  modport master (
    output enable, digit_data, dp_in, blank_mask, brightness, upd_req,
    input  upd_ack, seg_n, dp_n, an_n, frame_done
  );

  modport slave (
    input  enable, digit_data, dp_in, blank_mask, brightness, upd_req,
    output upd_ack, seg_n, dp_n, an_n, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// Each digit slot is CLK_DIV cycles: BLANK_CYCLES with all anodes off (ghosting
// guard), then the rest with one anode driven. The displayed values come from
// shadow registers that only change in IDLE or at a frame boundary, so a frame
// never shows a half-updated number. All outputs are registered and are derived
// from the next-state values, so anode and segment changes land on the same edge.
module seven_seg_scan_ctrl #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic                  ACLK,
  input logic                  ARESET,
  seven_seg_scan_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // Sequencing state
  state_t           state_reg, state_next;
  logic [1:0]       digit_idx_reg, digit_idx_next;
  logic [CNT_W-1:0] slot_cnt_reg, slot_cnt_next;
  logic [3:0]       pwm_reg, pwm_next;
  logic             idle_loaded_reg, idle_loaded_next;

  // Shadow copies of the display inputs
  logic [15:0]      digit_shadow_reg;
  logic [3:0]       dp_shadow_reg;
  logic [3:0]       mask_shadow_reg;
  logic [3:0]       bright_shadow_reg;

  // Registered outputs
  logic [3:0]       an_n_reg, an_n_next;
  logic [6:0]       seg_n_reg, seg_n_next;
  logic             dp_n_reg, dp_n_next;
  logic             upd_ack_reg, upd_ack_next;
  logic             frame_done_reg, frame_done_next;

  logic             frame_end;
  logic             load;
  logic [3:0]       nibble [4];

  // Split the shadow word into per-digit nibbles
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nibble
      assign nibble[gi] = digit_shadow_reg[4*gi +: 4];
    end
  endgenerate

  // Standard active-low hex decode, segments g..a in bits [6:0]
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Last DRIVE cycle of digit 3 is the frame boundary
  assign frame_end = (state_reg == DRIVE) && (digit_idx_reg == 2'd3) &&
                     (slot_cnt_reg == SLOT_LAST);

  // State, counters, shadows and output registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg         <= IDLE;
      digit_idx_reg     <= 2'd0;
      slot_cnt_reg      <= '0;
      pwm_reg           <= 4'd0;
      idle_loaded_reg   <= 1'b0;
      digit_shadow_reg  <= 16'h0000;
      dp_shadow_reg     <= 4'h0;
      mask_shadow_reg   <= 4'h0;
      bright_shadow_reg <= 4'hF;
      an_n_reg          <= 4'hF;
      seg_n_reg         <= 7'h7F;
      dp_n_reg          <= 1'b1;
      upd_ack_reg       <= 1'b0;
      frame_done_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      digit_idx_reg   <= digit_idx_next;
      slot_cnt_reg    <= slot_cnt_next;
      pwm_reg         <= pwm_next;
      idle_loaded_reg <= idle_loaded_next;
      if (load) begin
        digit_shadow_reg  <= bus.digit_data;
        dp_shadow_reg     <= bus.dp_in;
        mask_shadow_reg   <= bus.blank_mask;
        bright_shadow_reg <= bus.brightness;
      end
      an_n_reg       <= an_n_next;
      seg_n_reg      <= seg_n_next;
      dp_n_reg       <= dp_n_next;
      upd_ack_reg    <= upd_ack_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Next-state: slot sequencing; enable low always falls back to IDLE
  always_comb begin
    state_next     = state_reg;
    digit_idx_next = digit_idx_reg;
    slot_cnt_next  = slot_cnt_reg;
    if (!bus.enable) begin
      state_next     = IDLE;
      digit_idx_next = 2'd0;
      slot_cnt_next  = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next     = BLANK;
          digit_idx_next = 2'd0;
          slot_cnt_next  = '0;
        end
        BLANK: begin
          slot_cnt_next = slot_cnt_reg + CNT_W'(1);
          if (slot_cnt_reg == BLANK_LAST) begin
            state_next = DRIVE;
          end
        end
        DRIVE: begin
          if (slot_cnt_reg == SLOT_LAST) begin
            state_next     = BLANK;
            slot_cnt_next  = '0;
            digit_idx_next = digit_idx_reg + 2'd1;
          end else begin
            slot_cnt_next = slot_cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next     = IDLE;
          digit_idx_next = 2'd0;
          slot_cnt_next  = '0;
        end
      endcase
    end
  end

  // Outputs: shadow loading, PWM gating and the next registered display values
  always_comb begin
    // In IDLE a held request loads once; leaving IDLE re-arms it
    load = (frame_end && bus.enable && bus.upd_req) ||
           ((state_reg == IDLE) && bus.upd_req && !idle_loaded_reg);
    idle_loaded_next = (state_next == IDLE) &&
                       (idle_loaded_reg || ((state_reg == IDLE) && bus.upd_req));
    upd_ack_next    = load;
    frame_done_next = frame_end && bus.enable;

    pwm_next = ((state_next == DRIVE) && (state_reg != DRIVE)) ? 4'd0 : pwm_reg + 4'd1;

    an_n_next  = 4'hF;
    seg_n_next = 7'h7F;
    dp_n_next  = 1'b1;
    if (state_next == DRIVE) begin
      an_n_next = ~(4'b0001 << digit_idx_next);
      if (!mask_shadow_reg[digit_idx_next] && (pwm_next <= bright_shadow_reg)) begin
        seg_n_next = hex_to_seg(nibble[digit_idx_next]);
        dp_n_next  = ~dp_shadow_reg[digit_idx_next];
      end
    end
  end

  assign bus.an_n       = an_n_reg;
  assign bus.seg_n      = seg_n_reg;
  assign bus.dp_n       = dp_n_reg;
  assign bus.upd_ack    = upd_ack_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000: clock cycles per digit slot.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000: anodes-off cycles at the start of each slot; legal range 1..CLK_DIV-1.
REQ-003 SHALL have port ACLK, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port ARESET, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: scanning on while high.
REQ-006 SHALL have port digit_data, input, 16: four hex nibbles; digit i = bits [4i+3:4i].
REQ-007 SHALL have port dp_in, input, 4: decimal point per digit, 1 = lit.
REQ-008 SHALL have port blank_mask, input, 4: 1 = digit i forced dark.
REQ-009 SHALL have port brightness, input, 4: PWM duty, 0 = 1/16 through 15 = full.
REQ-010 SHALL have port upd_req, input, 1: level request to load the shadow registers.
REQ-011 SHALL have port upd_ack, output, 1: one-cycle pulse when the shadow registers load.
REQ-012 SHALL have port seg_n, output, 7: segments g..a in bits [6:0], active-low.
REQ-013 SHALL have port dp_n, output, 1: decimal point, active-low.
REQ-014 SHALL have port an_n, output, 4: digit anodes, active-low, one-hot-low or all high.
REQ-015 SHALL have port frame_done, output, 1: one-cycle pulse at the end of each four-digit frame.

Function
REQ-016 SHALL display only the shadow copies of digit_data, dp_in, blank_mask and brightness.
- Shadow registers load only under REQ-022/REQ-023.
REQ-017 SHALL implement FSM states IDLE, BLANK and DRIVE, plus a 2-bit digit_idx and a slot counter.
REQ-018 In IDLE, SHALL drive an_n=4'b1111, seg_n=7'h7F, dp_n=1 and digit_idx=0.
- Enters BLANK on the first cycle enable is sampled high.
REQ-019 In BLANK, SHALL hold anodes off for exactly BLANK_CYCLES cycles, then enter DRIVE.
REQ-020 In DRIVE, SHALL assert an_n[digit_idx] low for exactly CLK_DIV-BLANK_CYCLES cycles.
- Then increment digit_idx modulo 4 and return to BLANK.
- Slot length SHALL be exactly CLK_DIV cycles; frame length exactly 4*CLK_DIV cycles.
REQ-021 When the DRIVE slot of digit 3 ends, SHALL pulse frame_done for one cycle.
REQ-022 If upd_req is high at a frame boundary, SHALL load the shadows in that same cycle and pulse upd_ack once.
REQ-023 If upd_req is high while in IDLE, SHALL load the shadows and pulse upd_ack within one cycle.
- upd_req held high after upd_ack causes one further load per frame boundary.
REQ-024 Hex decode SHALL be standard, active-low, with g..a in bits [6:0].
- Values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-025 PWM: a 4-bit counter SHALL reset to 0 at each DRIVE entry and increment every cycle, wrapping.
- Segments and dp are lit only while the counter is <= the brightness shadow.
- an_n follows REQ-020 regardless of PWM.
REQ-026 A digit with its blank_mask shadow bit set SHALL keep its anode slot timing but show seg_n=7F and dp_n=1.
REQ-027 enable sampled low in any state SHALL force IDLE outputs on the next cycle, with no frame_done.
REQ-028 All outputs SHALL be registered.
- Anode and segment changes SHALL occur on the same edge.
- Two anodes SHALL never be low simultaneously.

Reset
REQ-029 ARESET high at a clock edge SHALL put the block in IDLE with an_n=F, seg_n=7F, dp_n=1, upd_ack=0 and frame_done=0.
- Shadows reset to digit 0x0000, dp 0, mask 0, brightness 15.
- Applies mid-operation; priority over enable and upd_req.

Verification (CLK_DIV=8, BLANK_CYCLES=2)
REQ-030 Reset:
- Stimulus: ARESET high 3 cycles, then enable=0.
- Response: an_n=F, seg_n=7F, dp_n=1 held indefinitely; upd_ack and frame_done never pulse.
REQ-031 Basic scan:
- Stimulus: digit_data=0x1234, upd_req pulse in IDLE, then enable=1.
- Response: an_n sequence E,D,B,7, each low 6 cycles separated by 2-cycle F gaps.
- seg_n per digit: 19, 30, 24, 79.
- frame_done pulses every 32 cycles.
REQ-032 Frame-boundary update:
- Stimulus: upd_req raised mid-frame with digit_data=0xFFFF.
- Response: displayed digits unchanged until the frame ends.
- upd_ack and frame_done pulse together; the next frame shows seg_n=0E on all digits.
REQ-033 Brightness and blanking:
- Stimulus: brightness=3, blank_mask=4'b0010.
- Response: segments lit cycles 0-3 of each 6-cycle DRIVE and dark cycles 4-5.
- Digit 1 anode pulses, but its seg_n stays 7F throughout.
REQ-034 Disable mid-operation:
- Stimulus: enable dropped during DRIVE of digit 2.
- Response: an_n=F next cycle, no frame_done.
- Re-enable restarts at digit 0 after 2 blank cycles.
REQ-035 Reset mid-operation:
- Stimulus: ARESET during DRIVE with a pending upd_req.
- Response: IDLE outputs next cycle and shadows at reset values.
- upd_ack only after reset is released.
